// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types, constants and memory model for the fetch responder
package ifetch_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, LOAD, RESP} state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b10,
        ERR_RANGE    = 2'b11
    } err_t;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_ADDR_SIZE = 32'h0800_0000;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    // Simulated physical memory: word contents derived from the byte offset
    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        return ((addr - DEF_ADDR_BASE) << 2) ^ 32'h0000_0413;
    endfunction

endpackage

// File: rtl/ifetch_mem_responder_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), advances every cycle
module lfsr16
    import ifetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_seed,
    output logic [15:0] o_value
);
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_lfsr <= i_seed;
        else          r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/ifetch_mem_responder.sv
// ifetch_mem_responder: valid/ready instruction-fetch responder with fixed
// plus optional pseudo-random latency and address error classification
module ifetch_mem_responder
    import ifetch_pkg::*;
#(
    parameter int unsigned  LATENCY   = 1,
    parameter bit           RAND_EN   = 1'b0,
    parameter logic [3:0]   RAND_MASK = 4'hF,
    parameter logic [15:0]  LFSR_SEED = 16'hACE1,
    parameter logic [31:0]  ADDR_BASE = DEF_ADDR_BASE,
    parameter logic [31:0]  ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [1:0]  o_resp_err,
    output logic [31:0] o_txn_cnt
);
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic [1:0]  r_resp_err;
    logic [31:0] r_txn_cnt;
    logic [31:0] r_pmem_reads;
    logic [15:0] w_lfsr;
    logic [4:0]  w_delay;
    err_t        w_err;
    logic        w_unused;

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_seed  (LFSR_SEED),
        .o_value (w_lfsr)
    );

    assign w_unused = ^w_lfsr[15:4];
    assign w_delay  = 5'(LATENCY) + (RAND_EN ? {1'b0, w_lfsr[3:0] & RAND_MASK} : 5'd0);
    // Offset compare wraps addresses below the base to large values
    assign w_err = (r_addr[1:0] != 2'b00)          ? ERR_MISALIGN
                 : ((r_addr - ADDR_BASE) >= ADDR_SIZE) ? ERR_RANGE
                 : ERR_OK;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 5'd0;
            r_addr       <= 32'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_err   <= ERR_OK;
            r_txn_cnt    <= 32'd0;
            r_pmem_reads <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        r_addr      <= i_req_addr;
                        r_cnt       <= w_delay;
                        r_req_ready <= 1'b0;
                        r_state     <= (w_delay == 5'd0) ? LOAD : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) r_state <= LOAD;
                end
                LOAD: begin
                    r_resp_err   <= w_err;
                    r_resp_data  <= (w_err == ERR_OK) ? pmem_read(r_addr) : 32'd0;
                    r_pmem_reads <= r_pmem_reads + ((w_err == ERR_OK) ? 32'd1 : 32'd0);
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_txn_cnt    <= r_txn_cnt + 32'd1;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign o_txn_cnt    = r_txn_cnt;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// tb_ifetch_mem_responder: directed checks of timing, errors, back-pressure,
// reset and randomized latency for ifetch_mem_responder
module tb_ifetch_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_rst_n = 1'b0, a_req_valid = 1'b0, a_resp_ready = 1'b1;
    logic        a_req_ready, a_resp_valid;
    logic [31:0] a_req_addr = 32'd0, a_resp_data, a_txn_cnt;
    logic [1:0]  a_resp_err;

    logic        b_rst_n = 1'b0, b_req_valid = 1'b0, b_resp_ready = 1'b1;
    logic        b_req_ready, b_resp_valid;
    logic [31:0] b_req_addr = 32'd0, b_resp_data, b_txn_cnt;
    logic [1:0]  b_resp_err;

    ifetch_mem_responder #(.LATENCY(1), .RAND_EN(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_addr(a_req_addr), .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
        .o_resp_data(a_resp_data), .o_resp_err(a_resp_err), .o_txn_cnt(a_txn_cnt)
    );

    ifetch_mem_responder #(.LATENCY(8), .RAND_EN(1'b1), .RAND_MASK(4'hF), .LFSR_SEED(16'hACE1)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_addr(b_req_addr), .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
        .o_resp_data(b_resp_data), .o_resp_err(b_resp_err), .o_txn_cnt(b_txn_cnt)
    );

    // Reference delay generator for dut_b
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge b_rst_n) begin
        if (!b_rst_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return ((a - 32'h8000_0000) * 32'd4) ^ 32'h0000_0413;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input bit b, input logic [31:0] addr, output int lat, output logic [15:0] lf);
        int n = 0;
        @(negedge clk);
        while (!(b ? b_req_ready : a_req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        lf = m_lfsr;
        if (b) begin b_req_valid = 1'b1; b_req_addr = addr; end
        else   begin a_req_valid = 1'b1; a_req_addr = addr; end
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        lat = 1;
        while (!(b ? b_resp_valid : a_resp_valid) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [31:0] a_addrs [6] = '{32'h8000_0000, 32'h8000_0002, 32'h7FFF_FFFC,
                                 32'h8800_0000, 32'h87FF_FFFC, 32'h7FFF_FFFE};
    logic [1:0]  a_errs  [6] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10};
    int lat1 [1000];
    int lat2 [1000];

    initial begin
        int lat, exp_reads, exp_txn, bad_range, bad_data, diffs, seen;
        logic [15:0] lf;
        exp_reads = 0;
        exp_txn = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_resp_data", a_resp_data, 32'd0);
        chk("rst_resp_err", 32'(a_resp_err), 32'd0);
        chk("rst_txn_cnt", a_txn_cnt, 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            fetch(1'b0, a_addrs[i], lat, lf);
            chk($sformatf("a%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("a%0d_err", i), 32'(a_resp_err), 32'(a_errs[i]));
            chk($sformatf("a%0d_data", i), a_resp_data, (a_errs[i] == 2'b00) ? exp_word(a_addrs[i]) : 32'd0);
            if (a_errs[i] == 2'b00) exp_reads++;
            chk($sformatf("a%0d_reads", i), dut_a.r_pmem_reads, 32'(exp_reads));
            if (i == 0) chk("a0_word_413", a_resp_data, 32'h0000_0413);
            @(negedge clk);
            exp_txn++;
            chk($sformatf("a%0d_txn", i), a_txn_cnt, 32'(exp_txn));
            chk($sformatf("a%0d_valid_low", i), 32'(a_resp_valid), 32'd0);
            chk($sformatf("a%0d_ready_back", i), 32'(a_req_ready), 32'd1);
        end

        a_resp_ready = 1'b0;
        fetch(1'b0, 32'h8000_0010, lat, lf);
        chk("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(a_resp_valid), 32'd1);
            chk("bp_data", a_resp_data, exp_word(32'h8000_0010));
            chk("bp_err", 32'(a_resp_err), 32'd0);
            chk("bp_req_ready", 32'(a_req_ready), 32'd0);
        end
        chk("bp_txn_hold", a_txn_cnt, 32'(exp_txn));
        a_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_low", 32'(a_resp_valid), 32'd0);
        chk("bp_req_ready", 32'(a_req_ready), 32'd1);
        chk("bp_txn_inc", a_txn_cnt, 32'(exp_txn + 1));

        fetch(1'b1, 32'h8000_0000, lat, lf);
        chk("b_first_lat", 32'(lat), 32'd10 + 32'(lf[3:0]));
        chk("b_first_data", b_resp_data, 32'h0000_0413);
        @(negedge clk);
        chk("b_first_txn", b_txn_cnt, 32'd1);

        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_addr = 32'h8000_0004;
        @(negedge clk);
        b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        b_rst_n = 1'b0;
        #1;
        chk("wrst_req_ready", 32'(b_req_ready), 32'd0);
        chk("wrst_resp_valid", 32'(b_resp_valid), 32'd0);
        chk("wrst_resp_data", b_resp_data, 32'd0);
        chk("wrst_resp_err", 32'(b_resp_err), 32'd0);
        chk("wrst_txn_cnt", b_txn_cnt, 32'd0);
        repeat (3) @(negedge clk);
        b_rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (b_resp_valid) seen++;
        end
        chk("wrst_no_resp", 32'(seen), 32'd0);
        chk("wrst_no_read", dut_b.r_pmem_reads, 32'd0);

        b_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        bad_range = 0;
        bad_data = 0;
        for (int i = 0; i < 1000; i++) begin
            fetch(1'b1, 32'h8000_0000 + 32'(i) * 4, lat, lf);
            lat1[i] = lat;
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'd10 + 32'(lf[3:0]));
            if (lat < 10 || lat > 25) bad_range++;
            if (b_resp_data !== exp_word(32'h8000_0000 + 32'(i) * 4) || b_resp_err !== 2'b00) bad_data++;
        end
        @(negedge clk);
        chk("rand_range", 32'(bad_range), 32'd0);
        chk("rand_data", 32'(bad_data), 32'd0);
        chk("rand_txn", b_txn_cnt, 32'd1000);

        b_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            fetch(1'b1, 32'h8000_0000 + 32'(i) * 4, lat, lf);
            lat2[i] = lat;
        end
        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 1000; i++) if (lat1[i] != lat2[i]) diffs++;
        chk("rand_repro", 32'(diffs), 32'd0);
        chk("rand_txn2", b_txn_cnt, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_mem_responder.md
Name: ifetch_mem_responder

Overview:
- Memory-side responder for the core's instruction-fetch port: accepts a fetch request through a valid/ready handshake, waits a configurable (optionally pseudo-random) delay, then returns the 32-bit word.
- Word contents come from the `pmem_read` DPI-C read function.
- Sits between the fetch stage and simulated physical memory.
- Replaces the unconditional per-cycle fetch, so the core can be exercised against multi-cycle memory.

Parameters:
- LATENCY, 1: fixed wait cycles added to every request, range 0..15.
- RAND_EN, 0: 1 adds a random extra delay of (lfsr[3:0] & RAND_MASK) cycles.
- RAND_MASK, 4'hF: mask on the random extra delay.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.
- ADDR_BASE, 32'h8000_0000: first valid byte address.
- ADDR_SIZE, 32'h0800_0000: size of the valid window in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address.
- resp_valid  out  1  response valid.
- resp_ready  in  1  requester accepts the response.
- resp_data  out  32  instruction word; 0 on error.
- resp_err  out  2  00 OK, 10 misaligned (addr[1:0]!=0), 11 out of window.
- txn_cnt  out  32  completed response handshakes, wraps at 2^32.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, txn_cnt=0, lfsr=LFSR_SEED.
  - Any in-flight request is dropped and no DPI call is made.
  - After release, req_ready=1 from the first rising edge.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
- IDLE:
  - req_ready=1, resp_valid=0.
  - On req_valid && req_ready: latch addr; set D = LATENCY + (RAND_EN ? lfsr[3:0]&RAND_MASK : 0), using a 5-bit counter.
  - D==0 -> go to LOAD; else go to WAIT with cnt=D.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - cnt==1 -> go to LOAD.
  - req_valid in this state is ignored; the requester must hold it.
- LOAD (one cycle):
  - Classify the latched address: misaligned takes priority over out-of-window.
  - Window check: addr-ADDR_BASE < ADDR_SIZE, computed as a 32-bit unsigned compare. Addresses below ADDR_BASE wrap to large values and fail the check.
  - OK: call pmem_read(addr) exactly once and register the result into resp_data.
  - Error: no DPI call; resp_data=0.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err held stable until handshake.
  - On resp_valid && resp_ready: txn_cnt++, go to IDLE.
  - No request is accepted in the same cycle as the handshake, so the minimum spacing is one IDLE cycle.
- Latency: accept edge to first cycle with resp_valid=1 is D+2 cycles, e.g. D=0 -> 2.
- Error responses use the same timing as OK responses and count in txn_cnt.
- Back-pressure: resp_ready low holds RESP indefinitely; the LFSR keeps running, which does not affect the held response.
- Reset asserted in any state returns to IDLE immediately; no partial response is ever visible.

Decomposition:
- Shared package `ifetch_pkg`:
  - state enum {IDLE, WAIT, LOAD, RESP} (2 bits);
  - resp_err codes ERR_OK / ERR_MISALIGN / ERR_RANGE;
  - default ADDR_BASE / ADDR_SIZE constants.
- Sub-module `lfsr16` (clk, rst, seed -> 16-bit value) for the delay generator.
- FSM, counter, address check and DPI call stay in the top block.

Test Plan:
- Single fetch, LATENCY=1, RAND_EN=0: req at 0x8000_0000, memory word 0x0000_0413 -> resp_valid exactly 3 cycles after accept, resp_data=0x00000413, resp_err=00, txn_cnt=1.
- Misaligned fetch at 0x8000_0002 -> resp_err=10, resp_data=0, no pmem_read call (DPI call counter unchanged), same 3-cycle timing.
- Out-of-window fetches at 0x7FFF_FFFC and at ADDR_BASE+ADDR_SIZE -> resp_err=11 for both; ADDR_BASE+ADDR_SIZE-4 -> 00.
- Back-pressure: hold resp_ready=0 for 10 cycles -> resp_valid/data/err stable throughout, req_ready=0; then resp_ready=1 -> IDLE next cycle, txn_cnt increments by exactly 1.
- Reset in WAIT (LATENCY=8, rst low 4 cycles after accept) -> all outputs reset immediately, no response, no DPI call; next request behaves normally.
- RAND_EN=1, 1000 back-to-back fetches with a scoreboard:
  - every latency in [LATENCY+2, LATENCY+17];
  - same seed reproduces an identical latency sequence;
  - txn_cnt=1000.
